ps2_key_event: RTL and testbench

Turns the raw PS/2 scan-code byte stream into buffered, decoded key events. It sits between the `ps2_keyboard` byte receiver and consumers such as the seven-segment display and ASCII translation logic. It resolves the `E0`/`F0` prefixes and swallows the Pause sequence. It also tracks modifier and Caps Lock state, counts key presses, and queues events in a parametrised first-word-fall-through FIFO with a ready/valid pop interface.

---
 rtl/ps2_key_event.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ps2_key_event.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event.sv
// ps2_key_event
//
// Converts the raw PS/2 scan-code byte stream into decoded key events and
// queues them in a first-word-fall-through FIFO with a ready/valid pop side.
// The E0 (extended) and F0 (break) prefixes are folded into each event, the
// E1 Pause sequence is swallowed, and host/keyboard protocol bytes
// (00, AA, FA, FE, FF) are discarded.
//
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN
//   When defined, an auto-repeated make of the key currently held is neither
//   queued nor counted.
//
// Parameters:
//   FIFO_DEPTH  event queue depth (power of two, >= 2)
//   CNT_W       width of the key-press counter
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   in_valid     one-cycle strobe qualifying in_data
//   in_data      received scan-code byte
//   ev_valid     FIFO head holds an event
//   ev_ready     consumer pops the head when ev_valid & ev_ready
//   ev_code      head event scan code, prefixes stripped
//   ev_ext       head event carried an E0 prefix
//   ev_break     head event is a key release
//   ev_mods      {caps, alt, ctrl, shift} snapshot taken with the event
//   mods         live {caps, alt, ctrl, shift}
//   press_count  number of make events queued, wraps
//   overflow     sticky, an event was dropped because the FIFO was full
module ps2_key_event #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [3:0]       ev_mods,
    output logic [3:0]       mods,
    output logic [CNT_W-1:0] press_count,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] mods;
    } entry_t;

    state_t     state, state_next;
    logic [2:0] skip_cnt, skip_next;

    logic dec_emit, dec_ext, dec_brk;
    logic suppress;
    logic push_req, do_push, do_pop;

    logic shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r, caps, caps_held;
    logic shift_l_n, shift_r_n, ctrl_l_n, ctrl_r_n, alt_l_n, alt_r_n, caps_n, caps_held_n;
    logic [3:0] mods_n;

    entry_t      mem [FIFO_DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;

    // Prefix decoder: only strobed bytes advance it. An event is emitted on
    // the byte that completes a make or break; the event code is that byte.
    // In SKIP the counter holds how many Pause bytes are still to be eaten.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        dec_emit   = 1'b0;
        dec_ext    = 1'b0;
        dec_brk    = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    case (in_data)
                        8'hE0: state_next = EXT;
                        8'hF0: state_next = BRK;
                        8'hE1: begin
                            state_next = SKIP;
                            skip_next  = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: state_next = IDLE;
                        default: dec_emit = 1'b1;
                    endcase
                end
                EXT: begin
                    case (in_data)
                        8'hF0: state_next = EXT_BRK;
                        8'hE0: state_next = EXT;
                        default: begin
                            dec_emit   = 1'b1;
                            dec_ext    = 1'b1;
                            state_next = IDLE;
                        end
                    endcase
                end
                BRK: begin
                    dec_emit   = 1'b1;
                    dec_brk    = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    dec_emit   = 1'b1;
                    dec_ext    = 1'b1;
                    dec_brk    = 1'b1;
                    state_next = IDLE;
                end
                SKIP: begin
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        state_next = IDLE;
                        skip_next  = 3'd0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    skip_next  = 3'd0;
                end
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_valid;
    logic       held_ext;
    logic [7:0] held_code;
    logic       held_match;

    assign held_match = held_valid && (held_code == in_data) && (held_ext == dec_ext);
    assign suppress   = dec_emit && !dec_brk && held_match;

    // Remember the most recently pressed key so its typematic repeats can be
    // recognised; releasing that key forgets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
        end else if (dec_emit) begin
            if (!dec_brk) begin
                held_valid <= 1'b1;
                held_ext   <= dec_ext;
                held_code  <= in_data;
            end else if (held_match) begin
                held_valid <= 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Next modifier state. Left/right ctrl and alt are told apart by the E0
    // prefix; shift keys are recognised by code alone. Caps toggles only on
    // the first make after a release so typematic repeats do not flip it.
    always_comb begin
        shift_l_n   = shift_l;
        shift_r_n   = shift_r;
        ctrl_l_n    = ctrl_l;
        ctrl_r_n    = ctrl_r;
        alt_l_n     = alt_l;
        alt_r_n     = alt_r;
        caps_n      = caps;
        caps_held_n = caps_held;
        if (dec_emit && !suppress) begin
            if (in_data == 8'h12) shift_l_n = !dec_brk;
            if (in_data == 8'h59) shift_r_n = !dec_brk;
            if (in_data == 8'h14) begin
                if (dec_ext) ctrl_r_n = !dec_brk;
                else         ctrl_l_n = !dec_brk;
            end
            if (in_data == 8'h11) begin
                if (dec_ext) alt_r_n = !dec_brk;
                else         alt_l_n = !dec_brk;
            end
            if (in_data == 8'h58) begin
                if (!dec_brk) begin
                    if (!caps_held) caps_n = !caps;
                    caps_held_n = 1'b1;
                end else begin
                    caps_held_n = 1'b0;
                end
            end
        end
    end

    assign mods_n = {caps_n, alt_l_n | alt_r_n, ctrl_l_n | ctrl_r_n, shift_l_n | shift_r_n};
    assign mods   = {caps, alt_l | alt_r, ctrl_l | ctrl_r, shift_l | shift_r};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign ev_valid = !fifo_empty;
    assign do_pop   = ev_valid && ev_ready;
    assign push_req = dec_emit && !suppress;
    assign do_push  = push_req && (!fifo_full || do_pop);

    assign head     = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_break = head.brk;
    assign ev_mods  = head.mods;

    // Event storage; the pointers alone define which entries are live, so
    // the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= '{code: in_data, ext: dec_ext, brk: dec_brk, mods: mods_n};
        end
    end

    // Decoder, modifier, pointer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            skip_cnt    <= 3'd0;
            shift_l     <= 1'b0;
            shift_r     <= 1'b0;
            ctrl_l      <= 1'b0;
            ctrl_r      <= 1'b0;
            alt_l       <= 1'b0;
            alt_r       <= 1'b0;
            caps        <= 1'b0;
            caps_held   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            press_count <= '0;
            overflow    <= 1'b0;
        end else begin
            state     <= state_next;
            skip_cnt  <= skip_next;
            shift_l   <= shift_l_n;
            shift_r   <= shift_r_n;
            ctrl_l    <= ctrl_l_n;
            ctrl_r    <= ctrl_r_n;
            alt_l     <= alt_l_n;
            alt_r     <= alt_r_n;
            caps      <= caps_n;
            caps_held <= caps_held_n;
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !dec_brk) press_count <= press_count + CNT_ONE;
            if (push_req && !do_push) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_event.sv
// tb_ps2_key_event
//
// Self-checking bench for ps2_key_event. A behavioural model (prefix flags,
// a queue of events, per-key "down" tables) predicts every output; directed
// sequences pin the model with literal values, then a long randomized run
// compares the DUT with the model on every cycle.
module tb_ps2_key_event;

    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             ev_valid;
    logic             ev_ready;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_break;
    logic [3:0]       ev_mods;
    logic [3:0]       mods;
    logic [CNT_W-1:0] press_count;
    logic             overflow;

    ps2_key_event #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_mods    (ev_mods),
        .mods       (mods),
        .press_count(press_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] code;
        bit         ext;
        bit         brk;
        logic [3:0] mods;
    } ev_t;

    ev_t              mq[$];
    bit               key_dn   [256];
    bit               key_dn_x [512];
    bit               m_caps;
    bit               m_ext_pf;
    bit               m_brk_pf;
    int               m_skip;
    logic [CNT_W-1:0] m_count;
    bit               m_ovf;
    bit               h_valid;
    logic [8:0]       h_key;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void modelReset();
        mq.delete();
        foreach (key_dn[i])   key_dn[i] = 1'b0;
        foreach (key_dn_x[i]) key_dn_x[i] = 1'b0;
        m_caps   = 1'b0;
        m_ext_pf = 1'b0;
        m_brk_pf = 1'b0;
        m_skip   = 0;
        m_count  = '0;
        m_ovf    = 1'b0;
        h_valid  = 1'b0;
        h_key    = '0;
    endfunction

    function automatic logic [3:0] modelMods();
        return {m_caps,
                key_dn_x[9'h011] | key_dn_x[9'h111],
                key_dn_x[9'h014] | key_dn_x[9'h114],
                key_dn[8'h12] | key_dn[8'h59]};
    endfunction

    function automatic void modelEmit(input logic [7:0] code, input bit ext, input bit brk);
        bit  sup = 1'b0;
        ev_t e;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!brk) begin
            if (h_valid && h_key == {ext, code}) sup = 1'b1;
            else begin
                h_valid = 1'b1;
                h_key   = {ext, code};
            end
        end else if (h_valid && h_key == {ext, code}) begin
            h_valid = 1'b0;
        end
`endif
        if (sup) return;
        if (code == 8'h58 && !brk && !key_dn[8'h58]) m_caps = !m_caps;
        key_dn[code]          = !brk;
        key_dn_x[{ext, code}] = !brk;
        e.code = code;
        e.ext  = ext;
        e.brk  = brk;
        e.mods = modelMods();
        if (mq.size() < FIFO_DEPTH) begin
            mq.push_back(e);
            if (!brk) m_count = m_count + 1'b1;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    // One clock of the model: the pop is decided from the queue as it stood
    // before the edge, then the byte is interpreted against pending prefixes.
    function automatic void modelStep(input bit r, input bit v, input logic [7:0] d, input bit rdy);
        if (r) begin
            modelReset();
            return;
        end
        if (mq.size() > 0 && rdy) mq.delete(0);
        if (!v) return;
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_brk_pf) begin
            modelEmit(d, m_ext_pf, 1'b1);
            m_ext_pf = 1'b0;
            m_brk_pf = 1'b0;
        end else if (d == 8'hF0) begin
            m_brk_pf = 1'b1;
        end else if (d == 8'hE0) begin
            m_ext_pf = 1'b1;
        end else if (!m_ext_pf && d == 8'hE1) begin
            m_skip = 7;
        end else if (!m_ext_pf && (d inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin
            // protocol byte, discarded
        end else begin
            modelEmit(d, m_ext_pf, 1'b0);
            m_ext_pf = 1'b0;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput();
        cmp("ev_valid", ev_valid, (mq.size() > 0));
        if (mq.size() > 0)
            cmp("head", {ev_code, ev_ext, ev_break, ev_mods},
                {mq[0].code, mq[0].ext, mq[0].brk, mq[0].mods});
        cmp("mods", mods, modelMods());
        cmp("press_count", press_count, m_count);
        cmp("overflow", overflow, m_ovf);
    endtask

    // Drive one cycle's inputs just after a falling edge, advance the model
    // by the same rising edge, then check on the next falling edge.
    task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d, input bit rdy);
        rst      = r;
        in_valid = v;
        in_data  = d;
        ev_ready = rdy;
        modelStep(r, v, d, rdy);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic sendByte(input logic [7:0] d, input bit rdy);
        applyStimulus(1'b0, 1'b1, d, rdy);
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [7:0] pickByte();
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 12) return 8'hF0;
        if (sel < 20) return 8'hE0;
        if (sel < 23) return 8'hE1;
        if (sel < 27) begin
            case ($urandom_range(0, 4))
                0: return 8'h00;
                1: return 8'hAA;
                2: return 8'hFA;
                3: return 8'hFE;
                default: return 8'hFF;
            endcase
        end
        if (sel < 50) begin
            case ($urandom_range(0, 4))
                0: return 8'h11;
                1: return 8'h12;
                2: return 8'h14;
                3: return 8'h58;
                default: return 8'h59;
            endcase
        end
        return 8'($urandom_range(1, 8'h83));
    endfunction

    initial begin
        logic [7:0] exp_order [8];
        int         n_ev;
        bit         r_b, v_b, rdy_b;
        int         rdy_pct;

        exp_order = '{8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1E};
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ev_ready = 1'b0;
        modelReset();
        @(negedge clk);

        // Reset values
        doReset();
        cmp("rst_ev_valid", ev_valid, 1'b0);
        cmp("rst_ev_fields", {ev_code, ev_ext, ev_break, ev_mods}, 14'h0);
        cmp("rst_mods", mods, 4'h0);
        cmp("rst_press_count", press_count, 8'd0);
        cmp("rst_overflow", overflow, 1'b0);

        // Make then break of 1C
        sendByte(8'h1C, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h1C, 1'b0);
        cmp("t1_first", {ev_code, ev_ext, ev_break}, {8'h1C, 1'b0, 1'b0});
        cmp("t1_count", press_count, 8'd1);
        idle(1'b1);
        cmp("t1_second", {ev_code, ev_ext, ev_break}, {8'h1C, 1'b0, 1'b1});
        idle(1'b1);
        cmp("t1_empty", ev_valid, 1'b0);

        // Shift snapshot
        sendByte(8'h12, 1'b0);
        sendByte(8'h1C, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h12, 1'b0);
        cmp("t2_mods_after_break", mods, 4'b0000);
        idle(1'b1);
        cmp("t2_1c_head", {ev_code, ev_mods}, {8'h1C, 4'b0001});
        repeat (FIFO_DEPTH) idle(1'b1);
        cmp("t2_count", press_count, 8'd3);

        // Extended make/break, then a Pause sequence that must vanish
        sendByte(8'hE0, 1'b0); sendByte(8'h75, 1'b0);
        sendByte(8'hE0, 1'b0); sendByte(8'hF0, 1'b0); sendByte(8'h75, 1'b0);
        sendByte(8'hE1, 1'b0); sendByte(8'h14, 1'b0); sendByte(8'h77, 1'b0);
        sendByte(8'hE1, 1'b0); sendByte(8'hF0, 1'b0); sendByte(8'h14, 1'b0);
        sendByte(8'hF0, 1'b0); sendByte(8'h77, 1'b0);
        cmp("t3_head", {ev_code, ev_ext, ev_break}, {8'h75, 1'b1, 1'b0});
        cmp("t3_mods", mods, 4'b0000);
        idle(1'b1);
        cmp("t3_second", {ev_code, ev_ext, ev_break}, {8'h75, 1'b1, 1'b1});
        idle(1'b1);
        cmp("t3_empty", ev_valid, 1'b0);
        sendByte(8'h1C, 1'b0);
        cmp("t3_idle_again", {ev_code, ev_ext, ev_break}, {8'h1C, 1'b0, 1'b0});
        repeat (FIFO_DEPTH) idle(1'b1);

        // Overflow, then simultaneous push and pop while full
        doReset();
        for (int i = 0; i < FIFO_DEPTH + 1; i++) sendByte(8'(8'h15 + i), 1'b0);
        cmp("t4_count", press_count, 8'd8);
        cmp("t4_overflow", overflow, 1'b1);
        cmp("t4_head", ev_code, 8'h15);
        sendByte(8'h1E, 1'b1);
        cmp("t4_count_pushpop", press_count, 8'd9);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            cmp("t4_order", ev_code, exp_order[i]);
            idle(1'b1);
        end
        cmp("t4_drained", ev_valid, 1'b0);
        cmp("t4_overflow_sticky", overflow, 1'b1);

        // Caps Lock toggling with a repeat
        doReset();
        sendByte(8'h58, 1'b0);
        cmp("t5_caps_on", mods[3], 1'b1);
        sendByte(8'h58, 1'b0);
        cmp("t5_caps_repeat", mods[3], 1'b1);
        sendByte(8'hF0, 1'b0); sendByte(8'h58, 1'b0);
        cmp("t5_caps_release", mods[3], 1'b1);
        sendByte(8'h58, 1'b0);
        cmp("t5_caps_off", mods[3], 1'b0);
        n_ev = 0;
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            if (ev_valid) n_ev++;
            idle(1'b1);
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        cmp("t5_event_count", n_ev, 3);
`else
        cmp("t5_event_count", n_ev, 4);
`endif

        // Reset in the middle of a prefix
        doReset();
        sendByte(8'h12, 1'b0);
        sendByte(8'hE0, 1'b0);
        sendByte(8'hF0, 1'b0);
        doReset();
        cmp("t6_valid", ev_valid, 1'b0);
        cmp("t6_mods", mods, 4'h0);
        cmp("t6_count", press_count, 8'd0);
        sendByte(8'h1C, 1'b0);
        cmp("t6_after", {ev_code, ev_ext, ev_break}, {8'h1C, 1'b0, 1'b0});
        cmp("t6_count_after", press_count, 8'd1);

        // Randomized run with phases of low, medium and high consumer readiness
        doReset();
        for (int i = 0; i < 6000; i++) begin
            case ((i / 400) % 3)
                0: rdy_pct = 10;
                1: rdy_pct = 50;
                default: rdy_pct = 90;
            endcase
            r_b   = ($urandom_range(0, 799) == 0);
            v_b   = ($urandom_range(0, 99) < 65);
            rdy_b = ($urandom_range(0, 99) < rdy_pct);
            applyStimulus(r_b, v_b, pickByte(), rdy_b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
